// File: rtl/spi_slave_port_if.sv
// Bus interface for spi_slave_port: SPI pins plus the RX/TX stream handshakes and error flags.
interface spi_slave_port_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  spi_in_SCLK;
    logic                  spi_in_SS_n;
    logic                  spi_in_MOSI;
    logic                  spi_in_MISO;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  rx_overrun;
    logic                  tx_underrun;
    logic                  err_clear;

    modport slave (
        input  spi_in_SCLK, spi_in_SS_n, spi_in_MOSI, rx_ready, tx_data, tx_valid, err_clear,
        output spi_in_MISO, rx_data, rx_valid, tx_ready, rx_overrun, tx_underrun
    );

    modport master (
        output spi_in_SCLK, spi_in_SS_n, spi_in_MOSI, rx_ready, tx_data, tx_valid, err_clear,
        input  spi_in_MISO, rx_data, rx_valid, tx_ready, rx_overrun, tx_underrun
    );
endinterface

// File: rtl/spi_slave_port.sv
// Mode-0 SPI slave: synchronized SPI pins, TX holding register, RX storage with sticky error flags.
// Define SPI_SLAVE_RX_FIFO_EN for a 4-entry RX FIFO; otherwise RX storage is a single word.
module spi_slave_port #(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] TX_IDLE    = '0
) (
    input  logic            clk_clk,
    input  logic            reset_reset_n,
    spi_slave_port_if.slave bus
);
    localparam int               CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

    state_e state_q, state_d;

    logic [1:0] sclk_sync_q, ss_sync_q, mosi_sync_q, settle_q;
    logic       sclk_prev_q, ss_high_q;
    logic       sclk_s, ss_s, mosi_s;
    logic       sclk_rise, sclk_fall, ss_fall;

    logic                  start_load, bit_rise, bit_fall, miso_en;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] tx_hold_q, tx_hold_d;
    logic                  tx_full_q, tx_full_d;
    logic                  rx_overrun_q, rx_overrun_d;
    logic                  tx_underrun_q, tx_underrun_d;

    logic                  word_done, tx_load, tx_accept;
    logic                  rx_full, rx_valid_w, rx_push, rx_pop;
    logic [DATA_WIDTH-1:0] rx_word, rx_head;

    // NOTE: sequential state is only ever assigned with <= so every flop sees pre-edge values.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            sclk_sync_q <= 2'b00;
            ss_sync_q   <= 2'b11;
            mosi_sync_q <= 2'b00;
            sclk_prev_q <= 1'b0;
            settle_q    <= 2'b00;
            ss_high_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], bus.spi_in_SCLK};
            ss_sync_q   <= {ss_sync_q[0], bus.spi_in_SS_n};
            mosi_sync_q <= {mosi_sync_q[0], bus.spi_in_MOSI};
            sclk_prev_q <= sclk_s;
            settle_q    <= {settle_q[0], 1'b1};
            ss_high_q   <= settle_q[1] & ss_s;
        end
    end

    assign sclk_s    = sclk_sync_q[1];
    assign ss_s      = ss_sync_q[1];
    assign mosi_s    = mosi_sync_q[1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    // A select only counts once a real high level has crossed the synchronizer since reset,
    // so a master still holding SS_n low across a reset cannot restart a frame mid-word.
    assign ss_fall   = ss_high_q & ~ss_s;

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal written in an always_comb gets a default first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (ss_fall) state_d = ACTIVE;
            ACTIVE:  if (ss_s)    state_d = IDLE;
        endcase
    end

    always_comb begin
        start_load = 1'b0;
        bit_rise   = 1'b0;
        bit_fall   = 1'b0;
        miso_en    = 1'b0;
        unique case (state_q)
            IDLE:    start_load = ss_fall;
            ACTIVE: begin
                miso_en  = 1'b1;
                bit_rise = sclk_rise & ~ss_s;
                bit_fall = sclk_fall & ~ss_s;
            end
        endcase
    end

    assign word_done = bit_rise & (bit_cnt_q == LAST_BIT);
    assign tx_load   = start_load | word_done;
    assign tx_accept = bus.tx_valid & ~tx_full_q;
    assign rx_word   = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
    assign rx_pop    = rx_valid_w & bus.rx_ready;
    assign rx_push   = word_done & (~rx_full | rx_pop);

    always_comb begin
        bit_cnt_d     = bit_cnt_q;
        rx_shift_d    = rx_shift_q;
        tx_shift_d    = tx_shift_q;
        tx_hold_d     = tx_hold_q;
        tx_full_d     = tx_full_q;

        if (state_d == IDLE) begin
            bit_cnt_d = '0;
        end else if (bit_rise) begin
            bit_cnt_d = word_done ? '0 : bit_cnt_q + CNT_W'(1);
        end

        if (bit_rise) begin
            rx_shift_d = rx_word;
        end

        // The falling edge just after a word completes (count back at 0) must keep the freshly loaded MSB.
        if (tx_load) begin
            tx_shift_d = tx_full_q ? tx_hold_q : TX_IDLE;
        end else if (bit_fall && bit_cnt_q != '0) begin
            tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
        end

        if (tx_accept) begin
            tx_hold_d = bus.tx_data;
            tx_full_d = 1'b1;
        end else if (tx_load) begin
            tx_full_d = 1'b0;
        end

        tx_underrun_d = (tx_load & ~tx_full_q) | (tx_underrun_q & ~bus.err_clear);
        rx_overrun_d  = (word_done & rx_full & ~rx_pop) | (rx_overrun_q & ~bus.err_clear);
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            bit_cnt_q     <= '0;
            rx_shift_q    <= '0;
            tx_shift_q    <= '0;
            tx_hold_q     <= '0;
            tx_full_q     <= 1'b0;
            rx_overrun_q  <= 1'b0;
            tx_underrun_q <= 1'b0;
        end else begin
            bit_cnt_q     <= bit_cnt_d;
            rx_shift_q    <= rx_shift_d;
            tx_shift_q    <= tx_shift_d;
            tx_hold_q     <= tx_hold_d;
            tx_full_q     <= tx_full_d;
            rx_overrun_q  <= rx_overrun_d;
            tx_underrun_q <= tx_underrun_d;
        end
    end

`ifdef SPI_SLAVE_RX_FIFO_EN
    localparam int RX_DEPTH = 4;

    logic [DATA_WIDTH-1:0] rx_mem_q [RX_DEPTH];
    logic [1:0]            rd_ptr_q, wr_ptr_q;
    logic [2:0]            rx_count_q;

    assign rx_full    = (rx_count_q == 3'd4);
    assign rx_valid_w = (rx_count_q != 3'd0);
    assign rx_head    = rx_mem_q[rd_ptr_q];

    // NOTE: the storage array is reset because rx_data must read zero straight out of reset.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < RX_DEPTH; i++) begin
                rx_mem_q[i] <= '0;
            end
            rd_ptr_q   <= 2'd0;
            wr_ptr_q   <= 2'd0;
            rx_count_q <= 3'd0;
        end else begin
            if (rx_push) begin
                rx_mem_q[wr_ptr_q] <= rx_word;
                wr_ptr_q           <= wr_ptr_q + 2'd1;
            end
            if (rx_pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            unique case ({rx_push, rx_pop})
                2'b10:   rx_count_q <= rx_count_q + 3'd1;
                2'b01:   rx_count_q <= rx_count_q - 3'd1;
                default: rx_count_q <= rx_count_q;
            endcase
        end
    end
`else
    logic [DATA_WIDTH-1:0] rx_data_q;
    logic                  rx_full_q;

    assign rx_full    = rx_full_q;
    assign rx_valid_w = rx_full_q;
    assign rx_head    = rx_data_q;

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            rx_data_q <= '0;
            rx_full_q <= 1'b0;
        end else begin
            if (rx_push) begin
                rx_data_q <= rx_word;
            end
            rx_full_q <= rx_push | (rx_full_q & ~rx_pop);
        end
    end
`endif

    assign bus.spi_in_MISO = miso_en & tx_shift_q[DATA_WIDTH-1];
    assign bus.rx_data     = rx_head;
    assign bus.rx_valid    = rx_valid_w;
    assign bus.tx_ready    = ~tx_full_q;
    assign bus.rx_overrun  = rx_overrun_q;
    assign bus.tx_underrun = tx_underrun_q;
endmodule

// File: tb/tb_spi_slave_port.sv
// Self-checking bench for spi_slave_port: a bit-banged mode-0 master with RX and MISO scoreboards.
module tb_spi_slave_port;
    localparam logic [7:0] TX_IDLE_W = 8'hE7;
`ifdef SPI_SLAVE_RX_FIFO_EN
    localparam int RX_DEPTH = 4;
`else
    localparam int RX_DEPTH = 1;
`endif

    logic clk_clk = 1'b0;
    logic reset_reset_n;
    always #5 clk_clk = ~clk_clk;

    spi_slave_port_if #(.DATA_WIDTH(8)) bus ();

    spi_slave_port #(
        .DATA_WIDTH (8),
        .TX_IDLE    (TX_IDLE_W)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .bus           (bus)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] rx_exp_q [$];
    logic [7:0] tx_exp_q [$];
    time        last_rise_t  = 0;
    time        last_valid_t = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // RX consumer: every accepted word must be the next one the master sent and the slave kept.
    always @(negedge clk_clk) begin
        if (reset_reset_n === 1'b1 && bus.rx_valid === 1'b1 && bus.rx_ready === 1'b1) begin
            last_valid_t = $time;
            if (rx_exp_q.size() == 0) begin
                check("rx_spurious_valid", 32'(bus.rx_valid), 32'd0);
            end else begin
                check("rx_data", 32'(bus.rx_data), 32'(rx_exp_q.pop_front()));
            end
        end
    end

    // Master bit loop at clk/8: MOSI changes with SCLK low, MISO captured at the rising edge.
    task automatic spi_word(input logic [7:0] mosi_w, input int nbits, output logic [7:0] miso_w);
        miso_w = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            bus.spi_in_MOSI = mosi_w[7-i];
            #40;
            miso_w          = {miso_w[6:0], bus.spi_in_MISO};
            bus.spi_in_SCLK = 1'b1;
            last_rise_t     = $time;
            #40;
            bus.spi_in_SCLK = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] mosi_w, input logic [7:0] miso_exp, input bit rx_kept);
        logic [7:0] got;
        if (rx_kept) rx_exp_q.push_back(mosi_w);
        tx_exp_q.push_back(miso_exp);
        spi_word(mosi_w, 8, got);
        check("miso_word", 32'(got), 32'(tx_exp_q.pop_front()));
    endtask

    task automatic ss_fall();
        bus.spi_in_SS_n = 1'b0;
        #80;
    endtask

    task automatic ss_rise();
        bus.spi_in_SS_n = 1'b1;
        #80;
    endtask

    task automatic pulse_clear();
        bus.err_clear = 1'b1;
        #10;
        bus.err_clear = 1'b0;
        #10;
    endtask

    task automatic offer_tx(input logic [7:0] w);
        bus.tx_data  = w;
        bus.tx_valid = 1'b1;
        #10;
        bus.tx_valid = 1'b0;
    endtask

    task automatic drain_rx();
        for (int i = 0; i < 100 && rx_exp_q.size() != 0; i++) #10;
        check("rx_drain_left", 32'(rx_exp_q.size()), 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] junk;
        bus.spi_in_SCLK = 1'b0;
        bus.spi_in_SS_n = 1'b1;
        bus.spi_in_MOSI = 1'b0;
        bus.rx_ready    = 1'b1;
        bus.tx_data     = 8'h00;
        bus.tx_valid    = 1'b0;
        bus.err_clear   = 1'b0;
        reset_reset_n   = 1'b0;
        @(posedge clk_clk);
        #2;
        #30;
        check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_rx_data", 32'(bus.rx_data), 32'd0);
        check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
        check("rst_rx_overrun", 32'(bus.rx_overrun), 32'd0);
        check("rst_tx_underrun", 32'(bus.tx_underrun), 32'd0);
        check("rst_miso", 32'(bus.spi_in_MISO), 32'd0);
        reset_reset_n = 1'b1;
        #50;

        // Preloaded TX word, 0xA5 received with latency check, then a reload from the holding register
        offer_tx(8'h3C);
        check("tx_ready_held", 32'(bus.tx_ready), 32'd0);
        ss_fall();
        check("tx_ready_after_load", 32'(bus.tx_ready), 32'd1);
        check("underrun_after_load", 32'(bus.tx_underrun), 32'd0);
        offer_tx(8'h96);
        xfer(8'hA5, 8'h3C, 1'b1);
        check("rx_valid_latency_ns", 32'(last_valid_t - last_rise_t), 32'd33);
        xfer(8'h4B, 8'h96, 1'b1);
        ss_rise();
        check("miso_idle_low", 32'(bus.spi_in_MISO), 32'd0);
        check("underrun_after_reload", 32'(bus.tx_underrun), 32'd1);
        pulse_clear();
        check("underrun_cleared", 32'(bus.tx_underrun), 32'd0);

        // No TX word pending: two idle words out
        ss_fall();
        xfer(8'h11, TX_IDLE_W, 1'b1);
        xfer(8'h22, TX_IDLE_W, 1'b1);
        ss_rise();
        check("underrun_idle_words", 32'(bus.tx_underrun), 32'd1);
        check("no_overrun_yet", 32'(bus.rx_overrun), 32'd0);
        pulse_clear();
        check("underrun_cleared2", 32'(bus.tx_underrun), 32'd0);
        drain_rx();

        // Consumer stalled: storage fills, the next word is dropped
        bus.rx_ready = 1'b0;
        ss_fall();
        for (int i = 0; i <= RX_DEPTH; i++) begin
            xfer(8'(i + 1), TX_IDLE_W, i < RX_DEPTH);
        end
        ss_rise();
        check("overrun_set", 32'(bus.rx_overrun), 32'd1);
        check("rx_valid_stalled", 32'(bus.rx_valid), 32'd1);
        check("rx_head_oldest", 32'(bus.rx_data), 32'h01);
        bus.rx_ready = 1'b1;
        drain_rx();
        pulse_clear();
        check("overrun_cleared", 32'(bus.rx_overrun), 32'd0);

        // Frame aborted after 5 bits, then a full 0x81
        ss_fall();
        spi_word(8'hFF, 5, junk);
        ss_rise();
        ss_fall();
        xfer(8'h81, TX_IDLE_W, 1'b1);
        ss_rise();
        drain_rx();
        check("overrun_after_abort", 32'(bus.rx_overrun), 32'd0);

        // Reset mid-word with SS_n still low; a new frame is needed to resume
        ss_fall();
        offer_tx(8'h77);
        spi_word(8'hFF, 4, junk);
        reset_reset_n = 1'b0;
        #10;
        check("mid_rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("mid_rst_rx_data", 32'(bus.rx_data), 32'd0);
        check("mid_rst_tx_ready", 32'(bus.tx_ready), 32'd1);
        check("mid_rst_underrun", 32'(bus.tx_underrun), 32'd0);
        check("mid_rst_overrun", 32'(bus.rx_overrun), 32'd0);
        check("mid_rst_miso", 32'(bus.spi_in_MISO), 32'd0);
        reset_reset_n = 1'b1;
        #40;
        spi_word(8'hC3, 8, junk);
        check("miso_ignored_after_rst", 32'(junk), 32'd0);
        ss_rise();
        ss_fall();
        xfer(8'h5E, TX_IDLE_W, 1'b1);
        ss_rise();
        drain_rx();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
